// File: rtl/if_prefetch_unit.sv
// Purpose: instruction-fetch front end; drives the ROM, queues {pc, inst} pairs, redirects on branch.
// Latency: a word fetched in cycle N is presented at the IF/ID boundary in cycle N+1 at the earliest.
// Backpressure: when the queue is full and decode does not pop, rom_ce_o drops and fetch_pc holds.
//
// Ports:
//   clk, rst                    - single clock, synchronous active-high reset
//   rom_ce_o, rom_addr_o        - ROM chip enable and byte address (address always equals fetch_pc)
//   rom_inst_i                  - combinational ROM word for rom_addr_o
//   branch_flag_i,
//   branch_target_address_i     - redirect request and target from decode
//   id_ready_i                  - decode accepts the head entry this cycle
//   if_valid_o, if_pc_o,
//   if_inst_o                   - head entry of the prefetch queue (pc/inst read 0 when not valid)
//   fifo_count_o                - current queue occupancy
module if_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    output logic             rom_ce_o,
    output logic [31:0]      rom_addr_o,
    input  logic [31:0]      rom_inst_i,
    input  logic             branch_flag_i,
    input  logic [31:0]      branch_target_address_i,
    input  logic             id_ready_i,
    output logic             if_valid_o,
    output logic [31:0]      if_pc_o,
    output logic [31:0]      if_inst_o,
    output logic [CNT_W-1:0] fifo_count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [31:0]       fetch_pc;
    logic [31:0]       pc_mem   [DEPTH];
    logic [31:0]       inst_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic not_empty;
    logic not_full;
    logic pop;
    logic push;

    assign not_empty = (count != '0);
    assign not_full  = (count < CNT_W'(DEPTH));

    // A redirect hides the head entry so nothing stale crosses into decode
    // during the cycle the queue is being flushed.
    assign if_valid_o = not_empty & ~branch_flag_i;
    assign pop        = if_valid_o & id_ready_i;

    // Fetching into a full queue is allowed only when the head leaves in the
    // same cycle, which keeps the ROM streaming at one word per cycle.
    assign push = (state == ST_RUN) & ~branch_flag_i & (not_full | pop);

    assign rom_ce_o     = push;
    assign rom_addr_o   = fetch_pc;
    assign if_pc_o      = if_valid_o ? pc_mem[rd_ptr]   : 32'h0;
    assign if_inst_o    = if_valid_o ? inst_mem[rd_ptr] : 32'h0;
    assign fifo_count_o = count;

    // Queue storage needs no reset: occupancy and pointers define what is live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            inst_mem[wr_ptr] <= rom_inst_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_WAIT;
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    // Redirects are ignored here; the first fetch uses RESET_PC.
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (branch_flag_i) begin
                        fetch_pc <= branch_target_address_i & 32'hFFFF_FFFC;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        count    <= '0;
                    end else begin
                        if (push) begin
                            wr_ptr   <= wr_ptr + PTR_W'(1);
                            fetch_pc <= fetch_pc + 32'd4;
                        end
                        if (pop) begin
                            rd_ptr <= rd_ptr + PTR_W'(1);
                        end
                        case ({push, pop})
                            2'b10:   count <= count + CNT_W'(1);
                            2'b01:   count <= count - CNT_W'(1);
                            default: count <= count;
                        endcase
                    end
                end
                default: state <= ST_WAIT;
            endcase
        end
    end

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the instruction ROM.
- Generates the fetch PC and drives the ROM's chip-enable and byte address.
- Captures the ROM's combinational instruction word into a small prefetch queue.
- Presents {pc, inst} pairs to the IF/ID boundary with a valid/ready handshake, and flushes/redirects on branch.

Parameters:
- DEPTH, 4, prefetch queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset; word aligned.
- CNT_W, 3, width of occupancy count; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- rom_ce_o  output  1  ROM chip enable; 1 = fetch this cycle.
- rom_addr_o  output  32  ROM byte address; always equal to the current fetch PC.
- rom_inst_i  input  32  ROM instruction word; combinational, valid in the same cycle as rom_addr_o when rom_ce_o=1.
- branch_flag_i  input  1  redirect request from decode.
- branch_target_address_i  input  32  redirect target.
- id_ready_i  input  1  decode can accept an instruction this cycle.
- if_valid_o  output  1  head entry valid this cycle.
- if_pc_o  output  32  PC of head entry.
- if_inst_o  output  32  instruction of head entry.
- fifo_count_o  output  CNT_W  current queue occupancy.

Behaviour:
- Clock and reset: single clock; synchronous active-high reset.
- Reset (rst=1 at an edge, including mid-operation):
  - State goes to WAIT; queue is emptied; read/write pointers go to 0.
  - fetch_pc goes to RESET_PC.
  - Outputs after the reset edge: rom_ce_o=0, rom_addr_o=RESET_PC, if_valid_o=0, if_pc_o=0, if_inst_o=0, fifo_count_o=0.
- State machine (2 states):
  - WAIT: rom_ce_o=0, no pushes. Moves to RUN on the first edge with rst=0.
  - RUN: stays in RUN until reset.
  - Effect: the first fetch occurs the cycle after reset deasserts.
- Pop:
  - pop = if_valid_o & id_ready_i.
  - if_valid_o = (count≠0) & ~branch_flag_i.
  - While if_valid_o=0, if_pc_o and if_inst_o read 0.
- Push:
  - Applies in RUN and branch_flag_i=0.
  - rom_ce_o = 1 when (count<DEPTH) or pop; otherwise rom_ce_o=0 (queue full and no pop).
  - When rom_ce_o=1, at the edge: write {fetch_pc, rom_inst_i} at the write pointer, then fetch_pc ← fetch_pc+4.
  - fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- Latency: a word fetched in cycle N is at the head (if_valid_o=1) in cycle N+1 at the earliest. No bypass from ROM to output.
- Simultaneous push and pop: count unchanged; both pointers advance. Pushing while full is legal only together with a pop.
- Pointer wrap: pointers increment modulo DEPTH.
- Count rules:
  - Never exceeds DEPTH; never underflows.
  - Pop at count=0 is impossible because if_valid_o=0.
- Redirect (branch_flag_i=1 in RUN):
  - That cycle: rom_ce_o=0, if_valid_o=0, no push or pop is counted.
  - At the edge: queue cleared (count=0, pointers=0), fetch_pc ← {branch_target_address_i[31:2], 2'b00}.
  - Fetch from the target starts the next cycle.
  - Back-to-back redirects: the last one wins.
  - Redirect in WAIT: ignored.
  - rst has priority over branch_flag_i.
- Ordering: instructions leave in strict fetch order; entries written before a redirect are never delivered after it.

Test Plan:
- Reset release, id_ready_i=1: cycle 1 rom_ce_o=1, addr 0x0. Then if_valid_o each cycle delivers pc 0x0, 0x4, 0x8, … with the matching ROM words; fifo_count_o stays ≤1.
- id_ready_i=0 from reset: pushes 0x0..0xC, then rom_ce_o=0, fifo_count_o=4, rom_addr_o holds 0x10. Raise id_ready_i: pops 0x0 while 0x10 is pushed the same cycle, and count stays 4.
- Queue holding 3 entries, branch_flag_i=1 with target 0x0000_0102: that cycle if_valid_o=0 and rom_ce_o=0. Next cycle count=0 and rom_addr_o=0x100. First delivered pc=0x100; stale entries are never output.
- fetch_pc preloaded via branch to 0xFFFF_FFF8, id_ready_i=1: fetched addresses are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4, delivered in that order.
- rst asserted mid-stream with count=3: the next cycle shows all outputs at reset values. The first fetch after release is RESET_PC, one cycle after rst drops.
- Random id_ready_i toggling over 1000 cycles against a reference queue model: delivered sequence matches, count matches the model, no loss or duplication.
